// File: rtl/exec_ctrl.sv
// exec_ctrl: fetch / operand / sequencing stage sitting directly in front of
// the ALU. It fetches one 27-bit instruction per pass, resolves operand 1 from
// the immediate or the input port, presents inst/arg1/arg2/acc to the ALU,
// writes the ALU result back to ACC, and owns PC, ACC, BAK, branching and the
// output-port handshake.
//
// Instruction word: [26:23] opcode, [22] src1 (0 = imm1, 1 = input port),
//                   [21:11] imm1, [10:0] imm2. All data is 11-bit signed.
//
// Handshakes (both ports): a word moves on a rising clk edge where
// valid && ready are both 1. valid, once raised by a producer, holds its data
// stable until that edge; ready carries no obligation.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_addr / imem_data      program memory address and same-cycle word
//   in_data/in_valid/in_ready  input port (consumer side)
//   out_data/out_valid/out_ready output port (producer side)
//   alu_inst/arg1/arg2/acc     ALU operand bus; meaningful in EXEC only
//   alu_out                    combinational ALU result
//   pc, acc                    debug views of PC and ACC
//   fsm_state                  debug view of the sequencer state
module exec_ctrl #(
  parameter int PC_W = 4,
  parameter int IW   = 27
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  input  logic [IW-1:0]   imem_data,
  input  logic [10:0]     in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [10:0]     out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_inst,
  output logic [10:0]     alu_arg1,
  output logic [10:0]     alu_arg2,
  output logic [10:0]     alu_acc,
  input  logic [10:0]     alu_out,
  output logic [PC_W-1:0] pc,
  output logic [10:0]     acc,
  output logic [1:0]      fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_OPERAND  = 2'd1,
    S_EXEC     = 2'd2,
    S_OUT_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_SWP = 4'd2;
  localparam logic [3:0] OP_SAV = 4'd3;
  localparam logic [3:0] OP_JMP = 4'd4;
  localparam logic [3:0] OP_JEZ = 4'd11;
  localparam logic [3:0] OP_JNZ = 4'd12;
  localparam logic [3:0] OP_JGZ = 4'd13;
  localparam logic [3:0] OP_JLZ = 4'd14;
  localparam logic [3:0] OP_OUT = 4'd15;

  state_t            state_q, state_d;
  logic [IW-1:0]     ir;
  logic [PC_W-1:0]   pc_q;
  logic [10:0]       acc_q, bak_q, arg1_q, arg2_q;

  logic [3:0]        opcode;
  logic              src1;
  logic [10:0]       imm1, imm2;
  logic [PC_W-1:0]   pc_inc, target;
  logic              in_fire;

  assign opcode = ir[26:23];
  assign src1   = ir[22];
  assign imm1   = ir[21:11];
  assign imm2   = ir[10:0];
  assign pc_inc = pc_q + 1'b1;          // natural wrap at 2**PC_W
  assign target = imm1[PC_W-1:0];

  assign in_ready  = (state_q == S_OPERAND) && src1;
  assign in_fire   = in_valid && in_ready;

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign acc       = acc_q;
  assign alu_acc   = acc_q;
  assign alu_inst  = opcode;
  assign alu_arg1  = arg1_q;
  assign alu_arg2  = arg2_q;
  assign fsm_state = state_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = S_OPERAND;
      S_OPERAND:  if (!src1 || in_fire) state_d = S_EXEC;
      S_EXEC:     state_d = (opcode == OP_OUT) ? S_OUT_WAIT : S_FETCH;
      S_OUT_WAIT: if (out_ready) state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Datapath: IR, operands, PC, ACC, BAK and the output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      pc_q      <= '0;
      acc_q     <= '0;
      bak_q     <= '0;
      arg1_q    <= '0;
      arg2_q    <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: ir <= imem_data;
        S_OPERAND: begin
          arg2_q <= imm2;
          if (!src1)        arg1_q <= imm1;
          else if (in_fire) arg1_q <= in_data;
        end
        S_EXEC: begin
          case (opcode)
            OP_NOP: pc_q <= pc_inc;
            OP_MOV: begin acc_q <= arg1_q; pc_q <= pc_inc; end
            OP_SWP: begin acc_q <= bak_q; bak_q <= acc_q; pc_q <= pc_inc; end
            OP_SAV: begin bak_q <= acc_q; pc_q <= pc_inc; end
            OP_JMP: pc_q <= target;
            OP_JEZ: pc_q <= (acc_q == 11'd0) ? target : pc_inc;
            OP_JNZ: pc_q <= (acc_q != 11'd0) ? target : pc_inc;
            OP_JGZ: pc_q <= (!acc_q[10] && acc_q != 11'd0) ? target : pc_inc;
            OP_JLZ: pc_q <= acc_q[10] ? target : pc_inc;
            // PC advances only when the output word is accepted
            OP_OUT: begin out_data <= arg1_q; out_valid <= 1'b1; end
            default: begin acc_q <= alu_out; pc_q <= pc_inc; end  // ALU ops 5..10
          endcase
        end
        S_OUT_WAIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            pc_q      <= pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  imem_addr;
  logic [26:0] imem_data;
  logic [10:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_inst;
  logic [10:0] alu_arg1, alu_arg2, alu_acc, alu_out;
  logic [3:0]  pc;
  logic [10:0] acc;
  logic [1:0]  fsm_state;

  logic [26:0] prog [16];
  logic        stub_en;
  logic [10:0] stub_val;

  // reference machine state (instruction level)
  logic [3:0]  m_pc;
  logic [10:0] m_acc, m_bak;
  logic [10:0] exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Test-side ALU: a fixed, easy-to-predict function of its inputs
  function automatic logic [10:0] alu_ref(input logic [3:0] i, input logic [10:0] a1,
                                          input logic [10:0] a2, input logic [10:0] ac);
    case (i)
      4'd5:    return ac + a1;
      4'd6:    return ac - a1;
      default: return ac ^ a1 ^ a2 ^ {7'd0, i};
    endcase
  endfunction

  function automatic logic [26:0] enc(input logic [3:0] op, input logic src,
                                      input logic [10:0] i1, input logic [10:0] i2);
    return {op, src, i1, i2};
  endfunction

  assign imem_data = prog[imem_addr];
  assign alu_out   = stub_en ? stub_val : alu_ref(alu_inst, alu_arg1, alu_arg2, alu_acc);

  exec_ctrl #(.PC_W(4), .IW(27)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .alu_inst(alu_inst), .alu_arg1(alu_arg1), .alu_arg2(alu_arg2),
    .alu_acc(alu_acc), .alu_out(alu_out),
    .pc(pc), .acc(acc), .fsm_state(fsm_state)
  );

  // Driver: reset, released on a falling edge so the next rising edge is a fetch
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc = '0; m_acc = '0; m_bak = '0;
    exp_q.delete();
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = '0;
  endtask

  // Driver + reference step: runs one instruction starting at a falling edge in
  // FETCH and ends at the falling edge of the next FETCH. Expected values come
  // from the instruction-level reference model below.
  task automatic step(input int in_delay, input logic [10:0] in_val, input int out_wait);
    logic [26:0] w;
    logic [3:0]  op, tgt, npc;
    logic        src;
    logic [10:0] i1, i2, a1, res, got;
    w = prog[m_pc];
    op = w[26:23]; src = w[22]; i1 = w[21:11]; i2 = w[10:0];
    a1 = src ? in_val : i1;
    tgt = i1[3:0];
    npc = m_pc + 4'd1;

    // FETCH
    n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL fetch_addr: got %0h want %0h", imem_addr, m_pc); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_fetch: got %b want 0", in_ready); end
    out_ready = 1'($urandom_range(0, 1));   // must be ignored while out_valid=0
    @(negedge clk);
    out_ready = 1'b0;

    // OPERAND
    if (src) begin
      in_valid = 1'b0;
      for (int i = 0; i < in_delay; i++) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_wait: got %b want 1", in_ready); end
        in_data = 11'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = in_val;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL in_ready_xfer: got %b want 1", in_ready); end
      @(negedge clk);
    end else begin
      in_valid = 1'($urandom_range(0, 1));  // not consumed
      in_data  = 11'($urandom);
      @(negedge clk);
    end

    // EXEC (in_valid may still be high: a second transfer must not happen)
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL in_ready_exec: got %b want 0", in_ready); end
    n_cmp++; if (alu_inst !== op) begin n_bad++; $display("FAIL alu_inst: got %0d want %0d", alu_inst, op); end
    n_cmp++; if (alu_arg1 !== a1) begin n_bad++; $display("FAIL alu_arg1: got %0h want %0h", alu_arg1, a1); end
    n_cmp++; if (alu_arg2 !== i2) begin n_bad++; $display("FAIL alu_arg2: got %0h want %0h", alu_arg2, i2); end
    n_cmp++; if (alu_acc !== m_acc) begin n_bad++; $display("FAIL alu_acc: got %0h want %0h", alu_acc, m_acc); end
    @(negedge clk);
    in_valid = 1'b0;

    // reference model of the instruction's effect
    res = stub_en ? stub_val : alu_ref(op, a1, i2, m_acc);
    case (op)
      4'd0: ;
      4'd1: m_acc = a1;
      4'd2: begin res = m_acc; m_acc = m_bak; m_bak = res; end
      4'd3: m_bak = m_acc;
      4'd4: npc = tgt;
      4'd11: if (m_acc == 0) npc = tgt;
      4'd12: if (m_acc != 0) npc = tgt;
      4'd13: if ($signed(m_acc) > 0) npc = tgt;
      4'd14: if ($signed(m_acc) < 0) npc = tgt;
      4'd15: exp_q.push_back(a1);
      default: m_acc = res;
    endcase

    // OUT_WAIT
    if (op == 4'd15) begin
      for (int i = 0; i < out_wait; i++) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL out_valid_hold: got %b want 1", out_valid); end
        n_cmp++; if (out_data !== a1) begin n_bad++; $display("FAIL out_data_hold: got %0h want %0h", out_data, a1); end
        n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL pc_hold: got %0h want %0h", pc, m_pc); end
        @(negedge clk);
      end
      out_ready = 1'b1;
      got = exp_q.pop_front();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== got) begin n_bad++; $display("FAIL out_xfer: got v=%b d=%0h want v=1 d=%0h", out_valid, out_data, got); end
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL out_valid_drop: got %b want 0", out_valid); end
    end

    m_pc = npc;
    n_cmp++; if (pc !== m_pc) begin n_bad++; $display("FAIL pc: got %0h want %0h", pc, m_pc); end
    n_cmp++; if (acc !== m_acc) begin n_bad++; $display("FAIL acc: got %0h want %0h", acc, m_acc); end
  endtask

  task automatic test_reset();
    clear_prog();
    do_reset();
    n_cmp++; if (pc !== 4'd0 || acc !== 11'd0 || imem_addr !== 4'd0) begin n_bad++; $display("FAIL reset_regs: pc=%0h acc=%0h addr=%0h want 0", pc, acc, imem_addr); end
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 11'd0) begin n_bad++; $display("FAIL reset_ports: ir=%b ov=%b od=%0h want 0", in_ready, out_valid, out_data); end
    n_cmp++; if (alu_inst !== 4'd0 || alu_arg1 !== 11'd0 || alu_arg2 !== 11'd0) begin n_bad++; $display("FAIL reset_alu: %0h %0h %0h want 0", alu_inst, alu_arg1, alu_arg2); end
  endtask

  task automatic test_program();
    clear_prog();
    prog[0] = enc(4'd1, 1'b0, 11'd7, 11'd0);   // MOV 7
    prog[1] = enc(4'd5, 1'b0, 11'd5, 11'd0);   // ADD 5
    prog[2] = enc(4'd3, 1'b0, 11'd0, 11'd0);   // SAV
    prog[3] = enc(4'd2, 1'b0, 11'd0, 11'd0);   // SWP
    prog[4] = enc(4'd1, 1'b0, 11'd1, 11'd0);   // MOV 1
    prog[5] = enc(4'd2, 1'b0, 11'd0, 11'd0);   // SWP -> ACC=12 exposes BAK
    do_reset();
    for (int i = 0; i < 6; i++) step(0, 11'd0, 0);
    n_cmp++; if (acc !== 11'd12) begin n_bad++; $display("FAIL prog_acc: got %0d want 12", acc); end
  endtask

  task automatic test_port_wait();
    clear_prog();
    prog[0] = enc(4'd1, 1'b1, 11'd0, 11'd0);   // MOV port
    do_reset();
    step(4, 11'h7FD, 0);
    n_cmp++; if (acc !== 11'h7FD) begin n_bad++; $display("FAIL port_acc: got %0h want 7fd", acc); end
  endtask

  task automatic test_branches();
    clear_prog();
    prog[0]  = enc(4'd1,  1'b0, 11'd0,   11'd0);  // MOV 0
    prog[1]  = enc(4'd11, 1'b0, 11'd9,   11'd0);  // JEZ 9 taken
    prog[9]  = enc(4'd13, 1'b0, 11'd2,   11'd0);  // JGZ 2 (first visit not taken)
    prog[10] = enc(4'd1,  1'b0, 11'h7FF, 11'd0);  // MOV -1
    prog[11] = enc(4'd14, 1'b0, 11'd3,   11'd0);  // JLZ 3 taken
    prog[3]  = enc(4'd12, 1'b0, 11'd6,   11'd0);  // JNZ 6 taken
    prog[6]  = enc(4'd11, 1'b0, 11'd1,   11'd0);  // JEZ not taken
    prog[7]  = enc(4'd13, 1'b0, 11'd1,   11'd0);  // JGZ not taken (negative)
    prog[8]  = enc(4'd1,  1'b0, 11'd5,   11'd0);  // MOV 5 -> JGZ at 9 now taken
    prog[2]  = enc(4'd4,  1'b0, 11'd2,   11'd0);  // JMP 2 self-loop
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 11'd0, 0);
    n_cmp++; if (pc !== 4'd2) begin n_bad++; $display("FAIL self_jump: got %0h want 2", pc); end
  endtask

  task automatic test_out();
    clear_prog();
    prog[0] = enc(4'd15, 1'b0, 11'd100, 11'd0);  // OUT 100
    do_reset();
    step(0, 11'd0, 3);
    step(0, 11'd0, 0);
  endtask

  task automatic test_wrap_and_alu();
    clear_prog();
    prog[0]  = enc(4'd4, 1'b0, 11'd15, 11'd0);   // JMP 15
    do_reset();
    step(0, 11'd0, 0);
    step(0, 11'd0, 0);                            // NOP at 15 -> 0
    n_cmp++; if (imem_addr !== 4'd0) begin n_bad++; $display("FAIL pc_wrap: got %0h want 0", imem_addr); end
    stub_en = 1'b1; stub_val = 11'h155;
    for (int op = 5; op <= 10; op++) begin
      clear_prog();
      prog[0] = enc(4'd1, 1'b0, 11'd3, 11'd0);
      prog[1] = enc(4'(op), 1'($urandom_range(0, 1)), 11'($urandom), 11'($urandom));
      do_reset();
      step(0, 11'd0, 0);
      step(int'($urandom_range(0, 2)), 11'($urandom), 0);
      n_cmp++; if (acc !== 11'h155) begin n_bad++; $display("FAIL alu_stub op%0d: got %0h want 155", op, acc); end
    end
    stub_en = 1'b0;
  endtask

  task automatic test_reset_mid_out();
    clear_prog();
    prog[0] = enc(4'd15, 1'b0, 11'd55, 11'd0);
    prog[1] = enc(4'd1,  1'b0, 11'd9,  11'd0);
    do_reset();
    step(0, 11'd0, 0);                            // out, PC -> 1
    step(0, 11'd0, 0);                            // ACC=9
    prog[2] = enc(4'd15, 1'b0, 11'd77, 11'd0);
    repeat (3) @(negedge clk);                    // now in OUT_WAIT
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL mid_out_valid: got %b want 1", out_valid); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || pc !== 4'd0 || acc !== 11'd0) begin n_bad++; $display("FAIL async_reset: ov=%b pc=%0h acc=%0h want 0", out_valid, pc, acc); end
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = '0; m_acc = '0; m_bak = '0; exp_q.delete();
    step(0, 11'd0, 1);                            // fetch from 0 again
  endtask

  task automatic test_random();
    clear_prog();
    for (int i = 0; i < 16; i++)
      prog[i] = enc(4'($urandom), 1'($urandom_range(0, 1)), 11'($urandom), 11'($urandom));
    do_reset();
    for (int i = 0; i < 200; i++)
      step(int'($urandom_range(0, 3)), 11'($urandom), int'($urandom_range(0, 3)));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    stub_en = 1'b0; stub_val = '0;
    m_pc = '0; m_acc = '0; m_bak = '0;
    clear_prog();
    #1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || pc !== 4'd0) begin n_bad++; $display("FAIL reset_at_start: ov=%b ir=%b pc=%0h", out_valid, in_ready, pc); end
    test_reset();
    test_program();
    test_port_wait();
    test_branches();
    test_out();
    test_wrap_and_alu();
    test_reset_mid_out();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
Name: exec_ctrl

Overview:
- Fetch/decode/sequencing stage directly upstream of the ALU.
- Fetches 27-bit instruction words from an external program memory and resolves operands from an immediate or the input port.
- Drives the ALU's inst/arg1/arg2/acc inputs, writes alu_out back to the accumulator, and owns PC, ACC, BAK, branches and the output-port handshake.
- All data is 11-bit two's complement (-1024..1023).

Parameters:
- PC_W, 4, program counter width; program memory depth is 2**PC_W words.
- IW, 27, instruction word width. Fixed encoding: [26:23] opcode, [22] src1 select (0 = imm1, 1 = input port), [21:11] imm1, [10:0] imm2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_addr  output  PC_W  program memory address; combinational read
- imem_data  input  IW  instruction at imem_addr, same cycle
- in_data  input  11  input port data
- in_valid  input  1  input port data valid
- in_ready  output  1  input port ready
- out_data  output  11  output port data
- out_valid  output  1  output port data valid
- out_ready  input  1  output port ready
- alu_inst  output  4  to ALU inst
- alu_arg1  output  11  to ALU arg1
- alu_arg2  output  11  to ALU arg2
- alu_acc  output  11  to ALU acc (equals ACC register)
- alu_out  input  11  ALU result, combinational
- pc  output  PC_W  current PC (debug)
- acc  output  11  current ACC (debug)

Behaviour:
- Reset (async, rst_n=0): PC=0, ACC=0, BAK=0, IR=0, state=FETCH. in_ready=0, out_valid=0, out_data=0, alu_inst=0, alu_arg1=0, alu_arg2=0 immediately, without waiting for a clock edge. Reset mid-handshake discards the transfer.
- FETCH: imem_addr=PC. At the edge, IR<=imem_data, go to OPERAND.
- OPERAND:
  - src1=0: ARG1<=imm1, go to EXEC next edge.
  - src1=1: in_ready=1. Stay until in_valid&&in_ready, then ARG1<=in_data and go to EXEC.
  - ARG2<=imm2 always.
- EXEC: alu_inst=IR opcode, alu_arg1=ARG1, alu_arg2=ARG2. One edge, then FETCH, except OUT (below).
- Minimum latency: 3 cycles per instruction; port-sourced operands add wait cycles.
- alu_inst/arg1/arg2 hold their registered values outside EXEC and are only meaningful during EXEC.
- Opcode actions at the EXEC edge. PC+1 wraps 2**PC_W-1 -> 0. Branch target T = imm1[PC_W-1:0].
  - 0 NOP: PC+1.
  - 1 MOV: ACC<=ARG1, PC+1.
  - 2 SWP: ACC<=BAK, BAK<=ACC (simultaneous), PC+1.
  - 3 SAV: BAK<=ACC, PC+1.
  - 4 JMP: PC<=T.
  - 5..10 (ADD/SUB/MUL/NOT/DGT/DST): ACC<=alu_out, PC+1. Saturation/wrap is the ALU's responsibility; alu_out is accepted as-is.
  - 11 JEZ: PC<=T if ACC==0, else PC+1.
  - 12 JNZ: PC<=T if ACC!=0, else PC+1.
  - 13 JGZ: PC<=T if ACC>0 (signed), else PC+1.
  - 14 JLZ: PC<=T if ACC<0 (signed), else PC+1.
  - 15 OUT: out_data<=ARG1, out_valid<=1, go to OUT_WAIT.
- OUT_WAIT: out_valid=1 and out_data stable until out_ready. At the handshake edge: out_valid<=0, PC+1, FETCH. out_ready while out_valid=0 is ignored.
- in_ready is 1 only in OPERAND with src1=1. in_valid in any other state is not consumed.
- ALU ops with src1=1 still wait for the input handshake before EXEC.
- Self-jump (T==PC) is legal: the instruction re-executes every 3 cycles.

Test Plan:
- Reset mid-OUT_WAIT: out_valid=1, assert rst_n=0 -> out_valid=0 and PC=0 before the next clk edge; after release, FETCH from addr 0.
- Program MOV 7; ADD imm1=5; OUT imm 0 is invalid, so use SAV, SWP -> ACC=12 after cycle 6. ALU sees inst=5, arg1=5, acc=7 in its EXEC cycle; after SWP, ACC=12 and BAK=12.
- MOV src1=port, in_valid held low 4 cycles then in_data=-3 -> in_ready high throughout the wait, one transfer, ACC=-3 (11'h7FD), instruction takes 4 extra cycles.
- Branches with ACC=0: JEZ T=9 -> PC=9; JGZ T=2 -> PC+1. With ACC=-1: JLZ T=3 -> PC=3; JNZ taken.
- OUT imm1=100 with out_ready low 3 cycles -> out_valid=1, out_data=100 stable 3+ cycles, single transfer, PC advances once.
- PC wrap: NOP at addr 15 (PC_W=4) -> next fetch addr 0. Each ALU opcode 5..10 with stubbed alu_out=11'h155 -> ACC=11'h155.
